// File: rtl/main_mem_burst.sv
// main_mem_burst: word-addressed memory model with a fixed access latency and line bursts.
//
// A request is accepted in idle, a programmable delay elapses, then a full line of BURST
// words is streamed one beat per cycle. Reads return the registered memory word for each
// beat; writes store wr_data_i on every beat edge (the beat still shows the old contents).
//
// Parameters:
//   LENGTH      memory depth in words (multiple of BURST)
//   BLOCK_SIZE  word width in bits
//   DELAY       edges from request accept to first visible beat (>= 2)
//   BURST       words per line (power of two, >= 1)
//
// Ports:
//   clk_i         clock, rising edge
//   reset_ni      synchronous active-low reset
//   req_valid_i   request present
//   req_ready_o   request can be accepted (idle only)
//   req_we_i      1 = write burst, 0 = read burst
//   req_addr_i    word address of the request
//   wr_data_i     write word, sampled on beat edges of a write burst
//   rd_data_o     read word, valid while beat_valid_o is high, held otherwise
//   beat_valid_o  data beat this cycle
//   beat_last_o   final beat of the burst
//   beat_addr_o   word address of the current beat, 0 outside beats
//
// Build option:
//   MAIN_MEM_CRITICAL_WORD_FIRST_EN  when defined the burst starts at the requested word and
//                                    wraps within the line; otherwise it starts at the line base.

module main_mem_burst #(
    parameter int unsigned LENGTH      = 1024,
    parameter int unsigned BLOCK_SIZE  = 32,
    parameter int unsigned DELAY       = 50,
    parameter int unsigned BURST       = 4,
    localparam int unsigned ADDR_LENGTH = $clog2(LENGTH),
    localparam int unsigned OFF_BITS    = $clog2(BURST)
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [ADDR_LENGTH-1:0] req_addr_i,
    input  logic [BLOCK_SIZE-1:0]  wr_data_i,
    output logic [BLOCK_SIZE-1:0]  rd_data_o,
    output logic                   beat_valid_o,
    output logic                   beat_last_o,
    output logic [ADDR_LENGTH-1:0] beat_addr_o
);

    // Zero-width counters are not legal, so BURST=1 still gets a 1-bit beat index.
    localparam int unsigned IdxW = (OFF_BITS == 0) ? 1 : OFF_BITS;
    localparam int unsigned DlyW = $clog2(DELAY);
    localparam logic [ADDR_LENGTH-1:0] OffMask = ADDR_LENGTH'((1 << OFF_BITS) - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StBurst
    } state_e;

    state_e                 state_q, state_d;
    logic [DlyW-1:0]        dly_q, dly_d;
    logic [ADDR_LENGTH-1:0] addr_q, addr_d;
    logic                   we_q, we_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [ADDR_LENGTH-1:0] beat_addr_q, beat_addr_d;
    logic [BLOCK_SIZE-1:0]  rd_data_q, rd_data_d;

    logic                   mem_we;
    logic [BLOCK_SIZE-1:0]  mem_rd [LENGTH];

    // Address of beat number idx within the line of req_addr.
    function automatic logic [ADDR_LENGTH-1:0] beat_addr_of(input logic [ADDR_LENGTH-1:0] a,
                                                            input logic [IdxW-1:0] idx);
        logic [ADDR_LENGTH-1:0] off;
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
        off = (a & OffMask) + ADDR_LENGTH'(idx);
`else
        off = ADDR_LENGTH'(idx);
`endif
        return (a & ~OffMask) | (off & OffMask);
    endfunction

    // ------------------------------------------------------------------------
    // Storage. Each word powers up holding its own index; reset leaves it alone.
    // A beat edge under reset must not write, so the reset gates the enable.
    // ------------------------------------------------------------------------
    assign mem_we = (state_q == StBurst) && we_q && reset_ni;

    for (genvar gi = 0; gi < LENGTH; gi++) begin : g_mem
        logic [BLOCK_SIZE-1:0] word_q = BLOCK_SIZE'(gi);

        always_ff @(posedge clk_i) begin
            if (mem_we && (beat_addr_q == ADDR_LENGTH'(gi))) begin
                word_q <= wr_data_i;
            end
        end

        assign mem_rd[gi] = word_q;
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            dly_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            beat_addr_q <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            beat_addr_q <= beat_addr_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. The beat address and read word are computed one edge
    // ahead so both are registered and line up with beat_valid_o.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        addr_d      = addr_q;
        we_d        = we_q;
        idx_d       = idx_q;
        beat_addr_d = beat_addr_q;
        rd_data_d   = rd_data_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    state_d = StWait;
                    addr_d  = req_addr_i;
                    we_d    = req_we_i;
                    dly_d   = '0;
                end
            end
            StWait: begin
                // Accept edge plus DELAY-1 further edges puts the first beat DELAY edges out.
                if (dly_q == DlyW'(DELAY - 2)) begin
                    state_d     = StBurst;
                    idx_d       = '0;
                    beat_addr_d = beat_addr_of(addr_q, '0);
                    rd_data_d   = mem_rd[beat_addr_d];
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            StBurst: begin
                if (idx_q == IdxW'(BURST - 1)) begin
                    state_d     = StIdle;
                    idx_d       = '0;
                    beat_addr_d = '0;
                end else begin
                    idx_d       = idx_q + 1'b1;
                    beat_addr_d = beat_addr_of(addr_q, idx_d);
                    rd_data_d   = mem_rd[beat_addr_d];
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        req_ready_o  = (state_q == StIdle);
        beat_valid_o = (state_q == StBurst);
        beat_last_o  = (state_q == StBurst) && (idx_q == IdxW'(BURST - 1));
        beat_addr_o  = beat_addr_q;
        rd_data_o    = rd_data_q;
    end

endmodule

// File: doc/main_mem_burst.md
MAIN_MEM_BURST -- requirements
Module: main_mem_burst

Interface
REQ-001 Parameter LENGTH, default 1024: memory depth in words; SHALL be a multiple of BURST.
REQ-002 Parameter BLOCK_SIZE, default 32: word width in bits.
REQ-003 Parameter DELAY, default 50: cycles from request accept to first data beat; SHALL be >= 2.
REQ-004 Parameter BURST, default 4: words per line; SHALL be a power of 2, >= 1.
REQ-005 Derived: ADDR_LENGTH = $clog2(LENGTH); OFF_BITS = $clog2(BURST).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset_n  input  1  synchronous, active-low reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block can accept a request.
REQ-010 req_we  input  1  1 = write burst, 0 = read burst.
REQ-011 req_addr  input  ADDR_LENGTH  word address of request.
REQ-012 wr_data  input  BLOCK_SIZE  write word; sampled on edges where beat_valid=1 during a write burst.
REQ-013 rd_data  output  BLOCK_SIZE  read word; valid while beat_valid=1.
REQ-014 beat_valid  output  1  data beat this cycle.
REQ-015 beat_last  output  1  final beat of burst; only high with beat_valid.
REQ-016 beat_addr  output  ADDR_LENGTH  word address of current beat.

Function
REQ-017 FSM states IDLE, WAIT, BURST; req_ready=1 only in IDLE.
REQ-018 IDLE: edge with req_valid=1 accepts request, latches req_addr and req_we, clears delay counter, moves to WAIT.
REQ-019 req_valid outside IDLE SHALL be ignored; no queueing.
REQ-020 Request accepted at edge N SHALL produce first beat_valid in the cycle following edge N+DELAY-1, i.e. DELAY edges after accept.
REQ-021 BURST: exactly BURST beats on consecutive cycles, no gaps; beat_last on the BURST-th; next cycle IDLE with req_ready=1.
REQ-022 Line base = req_addr with low OFF_BITS cleared; beat addresses stay within the line.
REQ-023 Read beat: rd_data = mem[beat_addr], registered, aligned with beat_valid.
REQ-024 Write beat: edge with beat_valid=1 writes wr_data to mem[beat_addr]; rd_data in that beat shows the pre-write contents.
REQ-025 Outside beats rd_data SHALL hold its last value; beat_addr SHALL be 0 when beat_valid=0.
REQ-026 Memory initialised at time zero to mem[i] = i (truncated to BLOCK_SIZE); not an effect of reset.
REQ-027 BURST=1: single beat with beat_last=1.

Reset
REQ-028 reset_n=0 at an edge: state IDLE, counter 0, req_ready=1 after reset deasserts, beat_valid=0, beat_last=0, beat_addr=0, rd_data=0.
REQ-029 Reset mid-WAIT or mid-BURST SHALL abandon the request; beats already written persist, no further writes; memory contents otherwise unchanged.
REQ-030 reset_n has priority over req_valid in the same cycle; no request accepted while reset_n=0.

Configuration
REQ-031 Macro MAIN_MEM_CRITICAL_WORD_FIRST_EN defined: first beat at req_addr, then offset incremented modulo BURST (wraps within line).
REQ-032 Macro undefined: beats at line base + 0, 1, ..., BURST-1 regardless of req_addr offset.

Verification (LENGTH=512, BLOCK_SIZE=32, BURST=4, DELAY=8 unless stated)
REQ-033 Read addr 10, macro off -> 8 edges after accept, rd_data 8,9,10,11 on 4 consecutive beats, beat_last on 11, req_ready next cycle.
REQ-034 Read addr 10, macro on -> rd_data 10,11,8,9; beat_addr 10,11,8,9; beat_last on 9.
REQ-035 Write addr 20 with wr_data 100,101,102,103 -> rd_data during write 20,21,22,23; then read addr 20 -> 100,101,102,103.
REQ-036 reset_n=0 at 3rd WAIT cycle of read 40 -> all outputs reset values, no beat; next read 40 completes normally with 40..43.
REQ-037 req_valid held high across a read of addr 508 -> one accept per burst; beats 508..511, no address beyond 511; second accept only after beat_last.
REQ-038 DELAY=2, BURST=1, read addr 7 -> single beat rd_data=7, beat_last=1, exactly 2 edges after accept.
